// File: rtl/pheap_defs_pkg.sv
// Shared types for the pipelined heap levels: key/value, stored entry, opcode and done codes.
package pheap_defs_pkg;

  parameter int LEVELS = 4;
  parameter int KEY_W  = 8;
  parameter int VAL_W  = 8;
  parameter int CAP_W  = LEVELS;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] value;
  } kv_t;

  typedef struct packed {
    kv_t              kv;
    logic             active;
    logic [CAP_W-1:0] cap;
  } entry_t;

  typedef enum logic [1:0] {
    LEQ     = 2'd0,
    DEQ     = 2'd1,
    ENQ_DEQ = 2'd2
  } opcode_t;

  typedef enum logic [1:0] {
    WAIT       = 2'd0,
    DONE       = 2'd1,
    NEXT_LEVEL = 2'd2
  } done_t;

  localparam kv_t KV_EMPTY = '0;

endpackage

// File: rtl/pheap_level_if.sv
// Request/response bundle between a heap level, its parent (master side) and its child.
interface pheap_level_if #(
  parameter int LEVEL = 2
);
  import pheap_defs_pkg::*;

  logic             start;
  opcode_t          op;
  kv_t              in;
  logic [LEVEL-2:0] addr;
  done_t            done;
  kv_t              out;
  logic             endPos;
  logic [LEVEL-2:0] raddrBot;

  modport master (output start, op, in, addr, input done, out, endPos, raddrBot);
  modport slave  (input start, op, in, addr, output done, out, endPos, raddrBot);

endinterface

// File: rtl/pheap_level.sv
// One non-root level of a pipelined max-heap: IDLE -> READ -> WRITE per request.
// Optional macro PHEAP_LEVEL_FWD_EN forwards the WRITE-cycle entry onto rTopL/rTopR.
module pheap_level
  import pheap_defs_pkg::*;
#(
  parameter int LEVEL = 2,
  parameter int LAST  = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  pheap_level_if.slave                        bus,
  input  logic [((LEVEL > 2) ? LEVEL-2 : 1)-1:0] raddrTop,
  output entry_t                              rTopL,
  output entry_t                              rTopR,
  input  entry_t                              rBotL,
  input  entry_t                              rBotR
);

  localparam int NODES = 2 ** (LEVEL - 1);
  localparam logic [CAP_W-1:0] CAP_RST = CAP_W'((2 ** (LEVELS - LEVEL + 1)) - 1);
  localparam entry_t ENTRY_NONE = '{kv: KV_EMPTY, active: 1'b0, cap: '0};

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t           state, state_nxt;
  opcode_t          op_q;
  kv_t              in_q;
  logic [LEVEL-2:0] addr_q;
  entry_t           mem [NODES];

  entry_t           node, bot_l, bot_r, child;
  logic             pick_r, any_child;
  logic [CAP_W-1:0] cap_dec, cap_inc;
  logic             wr_en;
  entry_t           wr_data;
  done_t            done_c;
  kv_t              out_c;
  logic             end_c;
  logic [LEVEL-2:0] rbot_c;
  logic [LEVEL-2:0] top_l, top_r;

  // NOTE: only flops use <=; every combinational value below is assigned with = in always_comb.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op_q   <= LEQ;
      in_q   <= KV_EMPTY;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start) begin
        op_q   <= bus.op;
        in_q   <= bus.in;
        addr_q <= bus.addr;
      end
    end
  end

  // NOTE: the entry array is reset because capacity is architectural state, not scratch data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NODES; i++) begin
        mem[i] <= '{kv: KV_EMPTY, active: 1'b0, cap: CAP_RST};
      end
    end else if (wr_en) begin
      mem[addr_q] <= wr_data;
    end
  end

  // The bottom level has no children: they look empty and full.
  assign bot_l     = (LAST != 0) ? ENTRY_NONE : rBotL;
  assign bot_r     = (LAST != 0) ? ENTRY_NONE : rBotR;
  assign node      = mem[addr_q];
  assign pick_r    = bot_r.active && (!bot_l.active || (bot_r.kv.key > bot_l.kv.key));
  assign any_child = bot_l.active || bot_r.active;
  assign child     = pick_r ? bot_r : bot_l;
  assign cap_dec   = (node.cap == '0) ? '0 : node.cap - 1'b1;
  assign cap_inc   = (node.cap >= CAP_RST) ? CAP_RST : node.cap + 1'b1;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    done_c    = DONE;
    out_c     = KV_EMPTY;
    end_c     = 1'b0;
    rbot_c    = '0;
    wr_en     = 1'b0;
    wr_data   = node;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = READ;
          done_c    = WAIT;
        end
      end
      READ: begin
        state_nxt = WRITE;
        done_c    = WAIT;
        rbot_c    = addr_q;
      end
      WRITE: begin
        state_nxt = IDLE;
        rbot_c    = addr_q;
        case (op_q)
          LEQ: begin
            if (!node.active) begin
              wr_en          = 1'b1;
              wr_data.kv     = in_q;
              wr_data.active = 1'b1;
              wr_data.cap    = cap_dec;
            end else if (node.cap != '0) begin
              wr_en       = 1'b1;
              wr_data.cap = cap_dec;
              if (in_q.key > node.kv.key) begin
                wr_data.kv = in_q;
                out_c      = node.kv;
              end else begin
                out_c = in_q;
              end
              end_c  = bot_r.cap > bot_l.cap;
              done_c = NEXT_LEVEL;
            end
          end
          DEQ: begin
            wr_en       = 1'b1;
            wr_data.cap = cap_inc;
            out_c       = node.kv;
            if (any_child) begin
              wr_data.kv = child.kv;
              end_c      = pick_r;
              done_c     = NEXT_LEVEL;
            end else begin
              wr_data.kv     = KV_EMPTY;
              wr_data.active = 1'b0;
            end
          end
          ENQ_DEQ: begin
            wr_en          = 1'b1;
            wr_data.active = 1'b1;
            if ((!bot_l.active || in_q.key > bot_l.kv.key) &&
                (!bot_r.active || in_q.key > bot_r.kv.key)) begin
              wr_data.kv = in_q;
            end else begin
              wr_data.kv = child.kv;
              out_c      = in_q;
              end_c      = pick_r;
              done_c     = NEXT_LEVEL;
            end
          end
          default: ;
        endcase
      end
      default: state_nxt = IDLE;
    endcase

    if (LAST != 0 && done_c == NEXT_LEVEL) done_c = DONE;

    if (!rst) begin
      wr_en  = 1'b0;
      done_c = DONE;
      out_c  = KV_EMPTY;
      end_c  = 1'b0;
      rbot_c = '0;
    end
  end

  assign bus.done     = done_c;
  assign bus.out      = out_c;
  assign bus.endPos   = end_c;
  assign bus.raddrBot = rbot_c;

  // Level 2 holds a single sibling pair, so raddrTop carries no address bits there.
  generate
    if (LEVEL > 2) begin : g_top_idx
      assign top_l = {raddrTop[LEVEL-3:0], 1'b0};
    end else begin : g_top_idx_root_pair
      assign top_l = raddrTop & 1'b0;
    end
  endgenerate
  assign top_r = top_l | {{(LEVEL-2){1'b0}}, 1'b1};

`ifdef PHEAP_LEVEL_FWD_EN
  always_comb begin
    rTopL = mem[top_l];
    rTopR = mem[top_r];
    if (wr_en && addr_q == top_l) rTopL = wr_data;
    if (wr_en && addr_q == top_r) rTopR = wr_data;
  end
`else
  assign rTopL = mem[top_l];
  assign rTopR = mem[top_r];
`endif

endmodule

// File: tb/tb_pheap_level.sv
// Directed bench for pheap_level at LEVEL=2 with LEVELS=4 (reset capacity 7).
module tb_pheap_level;
  import pheap_defs_pkg::*;

  logic   clk;
  logic   rst;
  logic   raddrTop;
  entry_t rTopL, rTopR, rBotL, rBotR;
  int     checks;
  int     errors;

  pheap_level_if #(.LEVEL(2)) bus ();

  pheap_level #(.LEVEL(2), .LAST(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .raddrTop (raddrTop),
    .rTopL    (rTopL),
    .rTopR    (rTopR),
    .rBotL    (rBotL),
    .rBotR    (rBotR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic kv_t kvm(input int k);
    kvm.key   = KEY_W'(k);
    kvm.value = VAL_W'(k + 16);
  endfunction

  function automatic entry_t ent(input kv_t kv, input logic act, input int cap);
    ent.kv     = kv;
    ent.active = act;
    ent.cap    = CAP_W'(cap);
  endfunction

  // Drives one request and samples done in IDLE(start), READ and WRITE plus WRITE outputs.
  task automatic run_op(input opcode_t op, input kv_t kv, input logic a,
                        input entry_t bl, input entry_t br,
                        output done_t d0, output done_t d1, output done_t d2,
                        output kv_t o, output logic ep, output logic rb);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.in    = kv;
    bus.addr  = a;
    rBotL     = bl;
    rBotR     = br;
    #1 d0 = bus.done;
    @(negedge clk);
    bus.start = 1'b0;
    #1 d1 = bus.done;
    @(negedge clk);
    #1;
    d2 = bus.done;
    o  = bus.out;
    ep = bus.endPos;
    rb = bus.raddrBot;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  done_t  d0, d1, d2;
  kv_t    o;
  logic   ep, rb;
  entry_t none;
  entry_t e0_reset;

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    raddrTop  = 1'b0;
    bus.start = 1'b0;
    bus.op    = LEQ;
    bus.in    = KV_EMPTY;
    bus.addr  = 1'b0;
    none      = ent(KV_EMPTY, 1'b0, 0);
    e0_reset  = ent(KV_EMPTY, 1'b0, 7);
    rBotL     = none;
    rBotR     = none;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    settle();

    check("reset_done", bus.done, DONE);
    check("reset_e0", rTopL, e0_reset);
    check("reset_e1", rTopR, e0_reset);

    // LEQ into an empty node
    run_op(LEQ, kvm(5), 1'b1, none, none, d0, d1, d2, o, ep, rb);
    check("leq_empty_d0", d0, WAIT);
    check("leq_empty_d1", d1, WAIT);
    check("leq_empty_d2", d2, DONE);
    settle();
    check("leq_empty_e1", rTopR, ent(kvm(5), 1'b1, 6));
    check("leq_empty_e0", rTopL, e0_reset);

    // LEQ into an active node: larger key stays, child with more capacity chosen
    run_op(LEQ, kvm(9), 1'b1, ent(kvm(1), 1'b1, 3), ent(kvm(2), 1'b1, 2), d0, d1, d2, o, ep, rb);
    check("leq_push_done", d2, NEXT_LEVEL);
    check("leq_push_out", o, kvm(5));
    check("leq_push_ep", ep, 1'b0);
    check("leq_push_raddrbot", rb, 1'b1);
    settle();
    check("leq_push_e1", rTopR, ent(kvm(9), 1'b1, 5));

    // DEQ promotes the larger child
    run_op(DEQ, KV_EMPTY, 1'b1, ent(kvm(4), 1'b1, 1), ent(kvm(7), 1'b1, 1), d0, d1, d2, o, ep, rb);
    check("deq_done", d2, NEXT_LEVEL);
    check("deq_out", o, kvm(9));
    check("deq_ep", ep, 1'b1);
    settle();
    check("deq_e1", rTopR, ent(kvm(7), 1'b1, 6));

    // ENQ_DEQ with the new key above both children stays here
    run_op(ENQ_DEQ, kvm(8), 1'b1, ent(kvm(3), 1'b1, 1), ent(kvm(6), 1'b1, 1), d0, d1, d2, o, ep, rb);
    check("enqdeq_keep_done", d2, DONE);
    check("enqdeq_keep_out", o, KV_EMPTY);
    settle();
    check("enqdeq_keep_e1", rTopR, ent(kvm(8), 1'b1, 6));

    // ENQ_DEQ with a smaller key promotes the larger child and pushes the key down
    run_op(ENQ_DEQ, kvm(2), 1'b1, ent(kvm(3), 1'b1, 1), ent(kvm(6), 1'b1, 1), d0, d1, d2, o, ep, rb);
    check("enqdeq_push_done", d2, NEXT_LEVEL);
    check("enqdeq_push_out", o, kvm(2));
    check("enqdeq_push_ep", ep, 1'b1);
    settle();
    check("enqdeq_push_e1", rTopR, ent(kvm(6), 1'b1, 6));

    // LEQ smaller key with equal child capacities goes left
    run_op(LEQ, kvm(1), 1'b1, ent(kvm(1), 1'b1, 2), ent(kvm(1), 1'b1, 2), d0, d1, d2, o, ep, rb);
    check("leq_tie_out", o, kvm(1));
    check("leq_tie_ep", ep, 1'b0);
    settle();
    check("leq_tie_e1", rTopR, ent(kvm(6), 1'b1, 5));

    // DEQ with no active child clears the node
    run_op(DEQ, KV_EMPTY, 1'b1, none, none, d0, d1, d2, o, ep, rb);
    check("deq_leaf_done", d2, DONE);
    check("deq_leaf_out", o, kvm(6));
    settle();
    check("deq_leaf_e1", rTopR, ent(KV_EMPTY, 1'b0, 6));

    // Capacity saturates at the reset value
    run_op(DEQ, KV_EMPTY, 1'b1, none, none, d0, d1, d2, o, ep, rb);
    run_op(DEQ, KV_EMPTY, 1'b1, none, none, d0, d1, d2, o, ep, rb);
    settle();
    check("cap_sat_e1", rTopR, ent(KV_EMPTY, 1'b0, 7));

    // Fill entry0 down to capacity 0, then overflow is refused
    for (int k = 0; k < 7; k++) begin
      run_op(LEQ, kvm(10 + k), 1'b0, ent(KV_EMPTY, 1'b0, 5), none, d0, d1, d2, o, ep, rb);
    end
    settle();
    check("fill_e0", rTopL, ent(kvm(16), 1'b1, 0));
    run_op(LEQ, kvm(20), 1'b0, ent(KV_EMPTY, 1'b0, 5), none, d0, d1, d2, o, ep, rb);
    check("ovf_done", d2, DONE);
    check("ovf_out", o, KV_EMPTY);
    settle();
    check("ovf_e0", rTopL, ent(kvm(16), 1'b1, 0));

    // start during READ is ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = LEQ;
    bus.in    = kvm(3);
    bus.addr  = 1'b1;
    rBotL     = none;
    rBotR     = none;
    @(negedge clk);
    bus.op = DEQ;
    bus.in = kvm(50);
    #1 check("busy_read_done", bus.done, WAIT);
    @(negedge clk);
    bus.start = 1'b0;
    #1 check("busy_write_done", bus.done, DONE);
    settle();
    check("busy_idle_done", bus.done, DONE);
    check("busy_e1", rTopR, ent(kvm(3), 1'b1, 6));

    // Reset asserted in READ drops the LEQ
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = LEQ;
    bus.in    = kvm(30);
    bus.addr  = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("rst_read_done", bus.done, DONE);
    check("rst_read_out", bus.out, KV_EMPTY);
    @(negedge clk);
    rst = 1'b1;
    settle();
    check("rst_after_done", bus.done, DONE);
    settle();
    check("rst_after_e0", rTopL, e0_reset);
    check("rst_after_e1", rTopR, e0_reset);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
